rvv_frontend_issue_buf: RTL and testbench
=========================================

Name: rvv_frontend_issue_buf

Overview:
RVS-side transmitter for the vector command queue. It stages vector instructions (not vsetvl/vsetvli/vsetivli) arriving from the scalar pipeline, up to 2 per cycle, in an in-order circular buffer. It presents up to `ISSUE_LANE instructions per cycle to the command queue using the lane-prefix valid/ready protocol. It also honours trap stop/flush from the RVV writeback stage.

Parameters:
DEPTH, 8, staging buffer entries; power of 2, at least `ISSUE_LANE.
NUM_CORE_IN, 2, instructions accepted per cycle from the scalar pipeline.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid_core  in  [NUM_CORE_IN] x 1  scalar-side instruction valid, prefix-ordered
inst_core  in  [NUM_CORE_IN] x INST_t  scalar-side instructions
inst_ready_core  out  [NUM_CORE_IN] x 1  per-lane accept
insts_valid_rvs2cq  out  [`ISSUE_LANE] x 1  lane valid to command queue
insts_rvs2cq  out  [`ISSUE_LANE] x INST_t  lane instruction to command queue
insts_ready_cq2rvs  in  [`ISSUE_LANE] x 1  command queue lane ready, prefix-ordered
stop_issue  in  1  trap pending; freeze all issue and accept
flush_issue  in  1  discard all buffered instructions
empty  out  1  buffer holds no instructions

Behaviour:
- State: rd_ptr and wr_ptr, each log2(DEPTH)+1 bits with a wrap bit. count = wr_ptr - rd_ptr, range 0..DEPTH. Entries are stored in registers.
- Reset (async, rst_n=0):
  - Pointers = 0, empty = 1.
  - All insts_valid_rvs2cq = 0 and all inst_ready_core = 0 while reset is asserted.
  - Stored entries are don't-care.
- Issue side:
  - insts_valid_rvs2cq[i] = (count > i) && !stop_issue.
  - insts_rvs2cq[i] = entry[rd_ptr+i], modulo DEPTH.
  - Valid is a prefix: valid[i] implies valid[i-1].
  - Valid depends only on registered state plus stop_issue. There is no combinational path from ready to valid.
- The CQ guarantees ready is a prefix. pop_n = number of lanes with valid[i] && ready[i]. rd_ptr advances by pop_n at the clock edge.
- A lane that is valid but not ready keeps the same instruction, in the same lane-relative order, in the next cycle. Lane 0 always carries the oldest instruction.
- Accept side:
  - inst_ready_core[j] = (DEPTH - count > j) && !stop_issue && !flush_issue.
  - Ready is computed from the current count. Same-cycle pops are not credited.
  - push_n = number of lanes with valid && ready. Writes start at wr_ptr in lane order; wr_ptr advances by push_n.
- A simultaneous push and pop in one cycle are both applied: count_next = count + push_n - pop_n. Pointer arithmetic wraps via the extra MSB. Full means count == DEPTH; empty means count == 0.
- flush_issue = 1:
  - Next cycle, rd_ptr = wr_ptr, so count = 0.
  - Pushes are blocked. Any pops in the same cycle are irrelevant.
  - Flush has priority over stop.
- stop_issue = 1: all valid and ready outputs are 0, and the pointers hold.
- Latency: an instruction accepted in cycle N is visible on lane 0 at N+1 at the earliest (buffer was empty, no stop).
- empty = (count == 0), registered-equivalent.

Optional Feature:
RVV_ISSUE_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [31:0].
  - It increments (saturating at 0xFFFF_FFFF) in every cycle where insts_valid_rvs2cq[0]=1 and insts_ready_cq2rvs[0]=0.
  - It is cleared by reset and by flush_issue.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package rvv_backend.svh: INST_t, `ISSUE_LANE, `NUM_DE_INST.
- Add `NUM_CORE_IN to the same package header.
- One natural sub-module: rvv_issue_ptr_ctrl. It computes push_n/pop_n popcounts and updates the pointers/count with wrap. The storage array stays in the top.

Test Plan:
- Reset, then push 2 instructions A, B in cycle 0 with CQ ready all 1 → cycle 1: valid = {0,0,1,1}, lane0 = A, lane1 = B; cycle 2: empty = 1.
- Fill to 8 with CQ ready all 0 → inst_ready_core = {0,0} at count 8. Next, CQ ready = {0,0,1,1} with 2 pushes offered in the same cycle → no push accepted, pop 2, count = 6; following cycle ready_core = {1,1}.
- Wrap: sustained push 2 / pop 1 from rd_ptr = 6 → lanes read entries 6, 7, 0, 1 in order. Instruction sequence is checked against the scoreboard across the wrap boundary.
- Partial accept: count = 4, CQ ready = {0,0,0,1} → next cycle lane0 holds the former lane1 instruction and count = 3.
- stop_issue held 3 cycles with count = 5 → valids and readies are 0 and count stays 5. On release, the same lane0 instruction is presented.
- flush_issue with count = 7 and 2 pushes offered → next cycle count = 0, empty = 1, no valid. With RVV_ISSUE_STALL_CNT_EN, stall_cnt = 0.

Source files
------------

// File: rtl/rvv_frontend_issue_buf_pkg.sv
// -----------------------------------------------------------------------------
// rvv_frontend_issue_buf_pkg
// Shared definitions for the RVS-side vector issue staging buffer.
//   `ISSUE_LANE  : lanes presented per cycle to the vector command queue
//   `NUM_DE_INST : decoded instructions per cycle on the backend side
//   `NUM_CORE_IN : instructions accepted per cycle from the scalar pipeline
//   INST_t       : one staged vector instruction (pc + raw encoding)
//   popcnt8      : population count used for lane-prefix push/pop counts
// The macros are guarded so that a project-wide definition takes precedence.
// -----------------------------------------------------------------------------
`ifndef ISSUE_LANE
`define ISSUE_LANE 4
`endif
`ifndef NUM_DE_INST
`define NUM_DE_INST 2
`endif
`ifndef NUM_CORE_IN
`define NUM_CORE_IN 2
`endif

package rvv_frontend_issue_buf_pkg;

    localparam int ISSUE_LANE  = `ISSUE_LANE;
    localparam int NUM_CORE_IN = `NUM_CORE_IN;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bits;
    } INST_t;

    // Lane counts never exceed 8, so an 8-bit mask covers every caller.
    function automatic logic [3:0] popcnt8(input logic [7:0] mask);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, mask[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rvv_frontend_issue_buf_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// rvv_frontend_issue_buf_ptr_ctrl
// Pointer/occupancy controller for the issue staging buffer. Owns the read and
// write pointers (index bits plus one wrap bit), derives the occupancy, the
// lane-prefix issue valids and accept readies, and advances the pointers by
// the number of completed handshakes.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_core_valid     : scalar-side valid per input lane (prefix)
//   i_cq_ready       : command-queue ready per issue lane (prefix)
//   i_stop, i_flush  : trap freeze / discard-all
//   o_rd_idx,o_wr_idx: storage indices of oldest entry / next free slot
//   o_issue_valid    : lane valids towards the command queue
//   o_accept_ready   : per-lane accept towards the scalar pipeline
//   o_push_en        : per-lane write strobe (valid && ready)
//   o_empty          : no instruction buffered
// -----------------------------------------------------------------------------
module rvv_frontend_issue_buf_ptr_ctrl
    import rvv_frontend_issue_buf_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_CORE_IN = 2,
    parameter int N_LANE      = 4
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_CORE_IN-1:0]     i_core_valid,
    input  logic [N_LANE-1:0]          i_cq_ready,
    input  logic                       i_stop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH)-1:0]   o_rd_idx,
    output logic [$clog2(DEPTH)-1:0]   o_wr_idx,
    output logic [N_LANE-1:0]          o_issue_valid,
    output logic [NUM_CORE_IN-1:0]     o_accept_ready,
    output logic [NUM_CORE_IN-1:0]     o_push_en,
    output logic                       o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_count;
    logic [PTR_W-1:0] w_free;
    logic [7:0]       w_pop_ext;
    logic [7:0]       w_push_ext;
    logic [3:0]       w_pop_n;
    logic [3:0]       w_push_n;

    // The wrap bit makes wr - rd the exact occupancy, including full (== DEPTH).
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_free  = PTR_W'(DEPTH) - w_count;

    // Lane-prefix valids/readies from registered occupancy only; ready is not
    // credited with same-cycle pops, and valid never looks at the CQ ready.
    always_comb begin
        o_issue_valid  = '0;
        o_accept_ready = '0;
        for (int i = 0; i < N_LANE; i++) begin
            if ((w_count > PTR_W'(i)) && !i_stop) begin
                o_issue_valid[i] = 1'b1;
            end else begin
                o_issue_valid[i] = 1'b0;
            end
        end
        for (int j = 0; j < NUM_CORE_IN; j++) begin
            if ((w_free > PTR_W'(j)) && !i_stop && !i_flush && i_rst_n) begin
                o_accept_ready[j] = 1'b1;
            end else begin
                o_accept_ready[j] = 1'b0;
            end
        end
    end

    assign o_push_en = i_core_valid & o_accept_ready;

    // Widen handshake masks so the shared 8-bit popcount can size them.
    always_comb begin
        w_pop_ext                    = 8'd0;
        w_push_ext                   = 8'd0;
        w_pop_ext[N_LANE-1:0]        = o_issue_valid & i_cq_ready;
        w_push_ext[NUM_CORE_IN-1:0]  = o_push_en;
    end

    assign w_pop_n  = popcnt8(w_pop_ext);
    assign w_push_n = popcnt8(w_push_ext);

    // Pointer update: flush drops everything (pops ignored), stop freezes both.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr;
        end else if (i_stop) begin
            r_rd_ptr <= r_rd_ptr;
            r_wr_ptr <= r_wr_ptr;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
        end
    end

    assign o_rd_idx = r_rd_ptr[IDX_W-1:0];
    assign o_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign o_empty  = (w_count == '0);

endmodule

// File: rtl/rvv_frontend_issue_buf.sv
// -----------------------------------------------------------------------------
// rvv_frontend_issue_buf
// RVS-side transmitter for the vector command queue. Stages up to NUM_CORE_IN
// vector instructions per cycle from the scalar pipeline in an in-order
// circular buffer and presents up to `ISSUE_LANE of them per cycle using the
// lane-prefix valid/ready protocol. Trap stop freezes issue and accept; flush
// discards all buffered instructions.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   inst_valid_core     : scalar-side valid per lane (prefix)
//   inst_core           : scalar-side instructions
//   inst_ready_core     : per-lane accept
//   insts_valid_rvs2cq  : lane valid to command queue (prefix, oldest on lane 0)
//   insts_rvs2cq        : lane instruction to command queue
//   insts_ready_cq2rvs  : command-queue lane ready (prefix)
//   stop_issue          : trap pending, freeze issue and accept
//   flush_issue         : discard all buffered instructions
//   empty               : buffer holds no instructions
//   stall_cnt           : (RVV_ISSUE_STALL_CNT_EN only) saturating count of
//                         cycles with lane 0 valid but not ready
// Optional feature macro: RVV_ISSUE_STALL_CNT_EN
// -----------------------------------------------------------------------------
module rvv_frontend_issue_buf
    import rvv_frontend_issue_buf_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_CORE_IN = rvv_frontend_issue_buf_pkg::NUM_CORE_IN
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CORE_IN-1:0]     inst_valid_core,
    input  INST_t                      inst_core [NUM_CORE_IN],
    output logic [NUM_CORE_IN-1:0]     inst_ready_core,
    output logic [ISSUE_LANE-1:0]      insts_valid_rvs2cq,
    output INST_t                      insts_rvs2cq [ISSUE_LANE],
    input  logic [ISSUE_LANE-1:0]      insts_ready_cq2rvs,
    input  logic                       stop_issue,
    input  logic                       flush_issue,
    output logic                       empty
`ifdef RVV_ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    INST_t                    r_entries [DEPTH];
    logic [IDX_W-1:0]         w_rd_idx;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [ISSUE_LANE-1:0]    w_issue_valid;
    logic [NUM_CORE_IN-1:0]   w_accept_ready;
    logic [NUM_CORE_IN-1:0]   w_push_en;
    logic                     w_empty;

    rvv_frontend_issue_buf_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .NUM_CORE_IN (NUM_CORE_IN),
        .N_LANE      (ISSUE_LANE)
    ) u_rvv_issue_ptr_ctrl (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_core_valid   (inst_valid_core),
        .i_cq_ready     (insts_ready_cq2rvs),
        .i_stop         (stop_issue),
        .i_flush        (flush_issue),
        .o_rd_idx       (w_rd_idx),
        .o_wr_idx       (w_wr_idx),
        .o_issue_valid  (w_issue_valid),
        .o_accept_ready (w_accept_ready),
        .o_push_en      (w_push_en),
        .o_empty        (w_empty)
    );

    // Storage write: lane j lands at wr_idx + j; accepted lanes form a prefix,
    // so slots stay contiguous. Contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_CORE_IN; j++) begin
            if (w_push_en[j]) begin
                r_entries[IDX_W'(w_wr_idx + IDX_W'(j))] <= inst_core[j];
            end
        end
    end

    // Issue read: lane i shows entry rd_idx + i (mod DEPTH), oldest on lane 0.
    always_comb begin
        for (int i = 0; i < ISSUE_LANE; i++) begin
            insts_rvs2cq[i] = r_entries[IDX_W'(w_rd_idx + IDX_W'(i))];
        end
    end

    assign insts_valid_rvs2cq = w_issue_valid;
    assign inst_ready_core    = w_accept_ready;
    assign empty              = w_empty;

`ifdef RVV_ISSUE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Back-pressure counter: lane 0 offered but refused; saturates, flush clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (flush_issue) begin
            r_stall_cnt <= 32'd0;
        end else if (w_issue_valid[0] && !insts_ready_cq2rvs[0]
                     && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rvv_frontend_issue_buf.sv
// -----------------------------------------------------------------------------
// tb_rvv_frontend_issue_buf
// Directed bench for rvv_frontend_issue_buf. Each step drives one cycle of
// stimulus with hand-computed lane valid / accept ready / empty expectations;
// instructions expected to be accepted are queued in a scoreboard and a
// separate monitor compares every presented lane against it and retires the
// handshaked ones.
// -----------------------------------------------------------------------------
module tb_rvv_frontend_issue_buf;
    import rvv_frontend_issue_buf_pkg::*;

    localparam int NC = NUM_CORE_IN;
    localparam int NL = ISSUE_LANE;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   inst_valid_core;
    INST_t           inst_core [NC];
    logic [NC-1:0]   inst_ready_core;
    logic [NL-1:0]   insts_valid_rvs2cq;
    INST_t           insts_rvs2cq [NL];
    logic [NL-1:0]   insts_ready_cq2rvs;
    logic            stop_issue;
    logic            flush_issue;
    logic            empty;
`ifdef RVV_ISSUE_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int     n_vec = 0;
    int     n_err = 0;
    int     next_id = 0;
    int     m_stall = 0;
    INST_t  exp_q [$];

    rvv_frontend_issue_buf #(.DEPTH(8), .NUM_CORE_IN(NC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .inst_valid_core    (inst_valid_core),
        .inst_core          (inst_core),
        .inst_ready_core    (inst_ready_core),
        .insts_valid_rvs2cq (insts_valid_rvs2cq),
        .insts_rvs2cq       (insts_rvs2cq),
        .insts_ready_cq2rvs (insts_ready_cq2rvs),
        .stop_issue         (stop_issue),
        .flush_issue        (flush_issue),
        .empty              (empty)
`ifdef RVV_ISSUE_STALL_CNT_EN
        ,
        .stall_cnt          (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic INST_t mk_inst(input int id);
        INST_t t;
        t.pc   = 32'h0000_1000 + 32'(id) * 32'd4;
        t.bits = 32'hA5A5_0057 ^ (32'(id) << 12);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive just after posedge, check at negedge, update the
    // scoreboard and stall model at the next posedge.
    task automatic step(input logic [1:0] vm, input logic [3:0] rdy,
                        input logic stp, input logic fl,
                        input logic [3:0] ev, input logic [1:0] er, input logic ee);
        inst_valid_core = vm;
        for (int j = 0; j < NC; j++) inst_core[j] = mk_inst(next_id + j);
        insts_ready_cq2rvs = rdy;
        stop_issue  = stp;
        flush_issue = fl;
        @(negedge clk);
        chk("lane_valid", 32'(insts_valid_rvs2cq), 32'(ev));
        chk("core_ready", 32'(inst_ready_core), 32'(er));
        chk("empty", 32'(empty), 32'(ee));
`ifdef RVV_ISSUE_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_stall = 0;
        end else begin
            for (int j = 0; j < NC; j++)
                if (vm[j] && er[j]) exp_q.push_back(mk_inst(next_id + j));
            if (ev[0] && !rdy[0]) m_stall++;
        end
        next_id += NC;
        #1;
    endtask

    // Monitor: every presented lane must match the scoreboard in order;
    // handshaked lanes retire their entries.
    always @(negedge clk) begin
        int popn;
        if (rst_n === 1'b1) begin
            popn = 0;
            for (int i = 0; i < NL; i++) begin
                if (insts_valid_rvs2cq[i]) begin
                    n_vec++;
                    if (i >= exp_q.size()) begin
                        n_err++;
                        $display("FAIL lane%0d_inst: got %h expected nothing", i, insts_rvs2cq[i]);
                    end else if (insts_rvs2cq[i] !== exp_q[i]) begin
                        n_err++;
                        $display("FAIL lane%0d_inst: got %h expected %h", i, insts_rvs2cq[i], exp_q[i]);
                    end
                    if (insts_ready_cq2rvs[i]) popn++;
                end
            end
            for (int k = 0; k < popn; k++)
                if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        rst_n              = 1'b0;
        inst_valid_core    = 2'b11;
        for (int j = 0; j < NC; j++) inst_core[j] = mk_inst(1000 + j);
        insts_ready_cq2rvs = 4'b0000;
        stop_issue         = 1'b0;
        flush_issue        = 1'b0;

        // Reset: no valids, no readies even though the core offers input.
        @(negedge clk);
        chk("rst_lane_valid", 32'(insts_valid_rvs2cq), 32'd0);
        chk("rst_core_ready", 32'(inst_ready_core), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
`ifdef RVV_ISSUE_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        inst_valid_core = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //     vm     rdy     stp   fl    ev       er     ee
        // A,B pushed, presented next cycle, drained after.
        step(2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        step(2'b00, 4'b1111, 1'b0, 1'b0, 4'b0011, 2'b11, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        // Fill to 8 with CQ stalled.
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0011, 2'b11, 1'b0);
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        // Full: pushes refused, pop 2; then ready again at count 6.
        step(2'b11, 4'b0011, 1'b0, 1'b0, 4'b1111, 2'b00, 1'b0);
        step(2'b00, 4'b0011, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        // rd at slot 6, count 4: push 2 / pop 1 across the wrap.
        step(2'b11, 4'b0001, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b11, 4'b0001, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b11, 4'b0001, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b11, 4'b0001, 1'b0, 1'b0, 4'b1111, 2'b01, 1'b0);
        // Drain 7 -> 3 -> 0.
        step(2'b00, 4'b1111, 1'b0, 1'b0, 4'b1111, 2'b01, 1'b0);
        step(2'b00, 4'b1111, 1'b0, 1'b0, 4'b0111, 2'b11, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        // Partial accept at count 4: lane 0 takes former lane 1, count 3.
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0011, 2'b11, 1'b0);
        step(2'b00, 4'b0001, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b0111, 2'b11, 1'b0);
        // Count 5, then stop held 3 cycles with everything offered.
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0111, 2'b11, 1'b0);
        step(2'b11, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        step(2'b11, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        step(2'b11, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        // Count 7, flush with 2 pushes offered, then empty.
        step(2'b11, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        step(2'b11, 4'b0000, 1'b0, 1'b1, 4'b1111, 2'b00, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        // Normal traffic after flush.
        step(2'b11, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);
        step(2'b00, 4'b1111, 1'b0, 1'b0, 4'b0011, 2'b11, 1'b0);
        step(2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
